// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decoder. Owns the program counter,
// issues one instruction-memory read at a time (no overlap, no prediction),
// holds the fetched word for the decoder and uses the decoder's next-PC
// select / halt flag to pick the next fetch address or stop the core.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_req_valid    read request to instruction memory (REQ state)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         request address, always equal to the PC
//   imem_rsp_valid    read data valid (only honoured in WAIT)
//   imem_rsp_data     read data
//   instr_valid       instr_out holds a valid instruction (HOLD state)
//   instr_out         fetched instruction word
//   instr_ready       decoder accepts instr_out this cycle
//   next_pc_sel       1 = PC+branch_imm, 0 = PC+4
//   branch_imm        signed byte offset for taken branches
//   is_halt           current instruction is HALT
//   pc_out            PC of the instruction held / being fetched
//   halted            core stopped; only rst clears it
//   fetch_count       instructions accepted downstream (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              instr_valid,
   output logic [31:0]       instr_out,
   input  logic              instr_ready,
   input  logic              next_pc_sel,
   input  logic [ADDR_W-1:0] branch_imm,
   input  logic              is_halt,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Branch targets are forced word-aligned by clearing the two low bits.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] branch_target;

   // Modulo-2^ADDR_W add; two's complement immediate falls out naturally.
   assign branch_target = (pc_q + branch_imm) & ALIGN_MASK;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      case (state_q)
         ST_REQ: begin
            if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               instr_d = imem_rsp_data;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Decoder inputs are only meaningful in the accept cycle.
            if (instr_ready) begin
               count_d = count_q + CNT_W'(1);
               if (is_halt) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_REQ;
                  pc_d    = next_pc_sel ? branch_target : (pc_q + ADDR_W'(4));
               end
            end
         end
         default: begin
            state_d = ST_HALTED;
         end
      endcase
   end

   // Output logic
   always_comb begin
      imem_req_valid = (state_q == ST_REQ);
      instr_valid    = (state_q == ST_HOLD);
      halted         = (state_q == ST_HALTED);
      imem_addr      = pc_q;
      pc_out         = pc_q;
      instr_out      = instr_q;
      fetch_count    = count_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed testbench for fetch_unit. Each scenario task drives the memory and
// decoder handshakes cycle by cycle and compares outputs one time unit after
// the rising edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic        instr_ready;
   logic        next_pc_sel;
   logic [31:0] branch_imm;
   logic        is_halt;
   logic [31:0] pc_out;
   logic        halted;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .instr_ready    (instr_ready),
      .next_pc_sel    (next_pc_sel),
      .branch_imm     (branch_imm),
      .is_halt        (is_halt),
      .pc_out         (pc_out),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      instr_ready    = 1'b0;
      next_pc_sel    = 1'b0;
      branch_imm     = 32'h0;
      is_halt        = 1'b0;
   endtask

   // Zero-wait fetch: request accepted, response next cycle, accepted in HOLD.
   task automatic fetch_one(input logic [31:0] data, input logic sel,
                            input logic [31:0] imm, input logic halt);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      tick();
      imem_rsp_valid = 1'b0;
      instr_ready    = 1'b1;
      next_pc_sel    = sel;
      branch_imm     = imm;
      is_halt        = halt;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %b expected 1", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h expected 00000000", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b expected 0", instr_valid); end
      checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out got %h expected 00000000", instr_out); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", halted); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d expected 0", fetch_count); end
      $display("test_reset done");
   endtask

   task automatic test_sequential;
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h expected %h", i, imem_addr, 32'(4 * i)); end
         checks++; if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_req_phase[%0d] got req=%b iv=%b expected req=1 iv=0", i, imem_req_valid, instr_valid); end
         imem_req_ready = 1'b1;
         tick();
         imem_req_ready = 1'b0;
         checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_phase[%0d] got req=%b iv=%b expected req=0 iv=0", i, imem_req_valid, instr_valid); end
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'h0;
         tick();
         imem_rsp_valid = 1'b0;
         checks++; if (instr_valid !== 1'b1 || pc_out !== 32'(4 * i)) begin errors++; $display("FAIL seq_hold[%0d] got iv=%b pc=%h expected iv=1 pc=%h", i, instr_valid, pc_out, 32'(4 * i)); end
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
         $display("seq fetch %0d accepted, next addr %h", i, imem_addr);
      end
      checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d expected 3", fetch_count); end
      checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_next_addr got %h expected 0000000c", imem_addr); end
   endtask

   // Starts in REQ at pc=0xC, count=3, instr_out=0; ends in HOLD.
   task automatic test_stall;
      for (int i = 0; i < 4; i++) begin
         imem_req_ready = 1'b0;
         imem_rsp_valid = (i == 1);
         imem_rsp_data  = 32'hDEAD_BEEF;
         tick();
         checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_req[%0d] got req=%b addr=%h expected req=1 addr=0000000c", i, imem_req_valid, imem_addr); end
         checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL stall_stray_rsp[%0d] got %h expected 00000000", i, instr_out); end
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      // req_ready left high in WAIT must be ignored.
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_wait[%0d] got req=%b iv=%b addr=%h expected 0 0 0000000c", i, imem_req_valid, instr_valid, imem_addr); end
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      tick();
      imem_rsp_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678) begin errors++; $display("FAIL stall_rsp got iv=%b data=%h expected iv=1 data=12345678", instr_valid, instr_out); end
      $display("test_stall done");
   endtask

   // Starts in HOLD at pc=0xC with instr 0x12345678, count=3.
   task automatic test_backpressure;
      for (int i = 0; i < 5; i++) begin
         instr_ready    = 1'b0;
         next_pc_sel    = i[0];
         branch_imm     = 32'h100;
         is_halt        = i[1];
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hCAFE_0000 + 32'(i);
         tick();
         checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678 || pc_out !== 32'hC) begin errors++; $display("FAIL bp_hold[%0d] got iv=%b data=%h pc=%h expected 1 12345678 0000000c", i, instr_valid, instr_out, pc_out); end
         checks++; if (imem_req_valid !== 1'b0 || fetch_count !== 32'd3 || halted !== 1'b0) begin errors++; $display("FAIL bp_idle[%0d] got req=%b cnt=%0d h=%b expected 0 3 0", i, imem_req_valid, fetch_count, halted); end
      end
      clear_inputs();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++; if (imem_addr !== 32'h10 || fetch_count !== 32'd4 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL bp_release got addr=%h cnt=%0d req=%b expected 00000010 4 1", imem_addr, fetch_count, imem_req_valid); end
      $display("test_backpressure done");
   endtask

   // Starts in REQ at pc=0x10, count=4.
   task automatic test_branch;
      fetch_one(32'h0000_1111, 1'b1, 32'hFFFF_FFF8, 1'b0);
      checks++; if (imem_addr !== 32'h08) begin errors++; $display("FAIL branch_back got %h expected 00000008", imem_addr); end
      fetch_one(32'h0000_2222, 1'b1, 32'h0000_0007, 1'b0);
      checks++; if (imem_addr !== 32'h0C) begin errors++; $display("FAIL branch_align got %h expected 0000000c", imem_addr); end
      fetch_one(32'h0000_3333, 1'b1, 32'h0000_0014, 1'b0);
      checks++; if (imem_addr !== 32'h20 || fetch_count !== 32'd7) begin errors++; $display("FAIL branch_fwd got addr=%h cnt=%0d expected 00000020 7", imem_addr, fetch_count); end
      $display("test_branch done");
   endtask

   // Starts in REQ at pc=0x20, count=7.
   task automatic test_halt;
      fetch_one(32'h0000_003F, 1'b0, 32'h0, 1'b1);
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_state got h=%b iv=%b expected 1 0", halted, instr_valid); end
      checks++; if (pc_out !== 32'h20 || fetch_count !== 32'd8) begin errors++; $display("FAIL halt_pc_cnt got pc=%h cnt=%0d expected 00000020 8", pc_out, fetch_count); end
      for (int i = 0; i < 20; i++) begin
         imem_req_ready = i[0];
         imem_rsp_valid = i[1];
         imem_rsp_data  = 32'h5555_0000;
         instr_ready    = 1'b1;
         tick();
         checks++; if (imem_req_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd8) begin errors++; $display("FAIL halt_stuck[%0d] got req=%b h=%b cnt=%0d expected 0 1 8", i, imem_req_valid, halted, fetch_count); end
      end
      clear_inputs();
      $display("test_halt done");
   endtask

   task automatic test_reset_mid;
      // Reset out of HALTED.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (halted !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'd0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_halted got h=%b addr=%h cnt=%0d req=%b expected 0 00000000 0 1", halted, imem_addr, fetch_count, imem_req_valid); end
      fetch_one(32'h0000_0044, 1'b0, 32'h0, 1'b0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      // In WAIT at pc=4, count=1; a response arriving with reset is dropped.
      rst            = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hAAAA_AAAA;
      tick();
      rst            = 1'b0;
      imem_rsp_valid = 1'b0;
      checks++; if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 32'h0) begin errors++; $display("FAIL rst_wait got req=%b iv=%b data=%h expected 1 0 00000000", imem_req_valid, instr_valid, instr_out); end
      checks++; if (imem_addr !== 32'h0 || fetch_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL rst_wait_regs got addr=%h cnt=%0d h=%b expected 00000000 0 0", imem_addr, fetch_count, halted); end
      $display("test_reset_mid done");
   endtask

   // Starts in REQ at pc=0 after reset.
   task automatic test_wrap;
      fetch_one(32'h0000_0001, 1'b1, 32'hFFFF_FFFC, 1'b0);
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h expected fffffffc", imem_addr); end
      fetch_one(32'h0000_0002, 1'b0, 32'h0, 1'b0);
      checks++; if (imem_addr !== 32'h0 || fetch_count !== 32'd2) begin errors++; $display("FAIL wrap_pc got addr=%h cnt=%0d expected 00000000 2", imem_addr, fetch_count); end
      $display("test_wrap done");
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_sequential();
      test_stall();
      test_backpressure();
      test_branch();
      test_halt();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
